// File: rtl/decode_pipe.sv
// Decode stage between IF/ID and ID/EX: field decode, register file with writeback
// bypass, multi-cycle load-use interlock and EX back-pressure with held-operand coherence.
module decode_pipe #(
    parameter int              XLEN         = 32,
    parameter int              REG_COUNT    = 32,
    parameter int              LOAD_LATENCY = 1,
    parameter logic [XLEN-1:0] BUBBLE_PC    = {XLEN{1'b1}},
    localparam int             RA           = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_flush,
    input  logic            if_id__valid,
    input  logic [XLEN-1:0] if_id__pc,
    input  logic [31:0]     if_id__ins,
    output logic            if_id__stall,
    input  logic            wb_id__rd_wen,
    input  logic [RA-1:0]   wb_id__rd_addr,
    input  logic [XLEN-1:0] wb_id__rd_wdata,
    input  logic            id_ex__ready,
    output logic            id_ex__valid,
    output logic [XLEN-1:0] id_ex__pc,
    output logic [XLEN-1:0] id_ex__imm,
    output logic [XLEN-1:0] id_ex__rs1_rdata,
    output logic [XLEN-1:0] id_ex__rs2_rdata,
    output logic [RA-1:0]   id_ex__rs1_addr,
    output logic [RA-1:0]   id_ex__rs2_addr,
    output logic [RA-1:0]   id_ex__rd_addr,
    output logic [17:0]     id_ex__ctrl
);

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_a_src;
        logic       alu_b_src;
        logic [1:0] dmem_width;
        logic       dmem_zero_ext;
        logic       dmem_read;
        logic       dmem_write;
        logic       jump_base_src;
        logic [1:0] jump_cond;
        logic       rd_wen;
        logic [1:0] rd_src;
    } ctrl_t;

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] COND_NEVER = 2'd0, COND_ALWAYS = 2'd1, COND_ZERO = 2'd2, COND_NONZERO = 2'd3;
    localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
    localparam logic [1:0] RD_ALU = 2'd0, RD_MEM = 2'd1, RD_PC4 = 2'd2;
    localparam ctrl_t      CTRL_BUBBLE = ctrl_t'({13'b0, COND_NEVER, 3'b0});
    localparam logic [2:0] CNT_INIT = 3'(LOAD_LATENCY - 1);

    logic [XLEN-1:0] rf_q [REG_COUNT];
    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [RA-1:0]   rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    ctrl_t           ctrl_q, ctrl_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RA-1:0]   rs1_dec, rs2_dec, rd_dec;
    logic [31:0]     imm32;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] rs1_read, rs2_read;
    logic            wb_live, hz, take_bubble, take_capture;

    assign opcode  = if_id__ins[6:0];
    assign funct3  = if_id__ins[14:12];
    assign rs1_dec = if_id__ins[15 +: RA];
    assign rs2_dec = if_id__ins[20 +: RA];
    assign rd_dec  = if_id__ins[7 +: RA];

    // alu_op is {sub/arith-shift bit, funct3}; branches compare via SUB/SLT/SLTU and test zero
    always_comb begin
        dec_ctrl = CTRL_BUBBLE;
        imm32    = '0;
        case (opcode)
            7'b0110011: begin
                dec_ctrl.alu_op = {if_id__ins[30], funct3};
                dec_ctrl.rd_wen = 1'b1;
            end
            7'b0010011: begin
                dec_ctrl.alu_op    = {(funct3 == 3'b101) & if_id__ins[30], funct3};
                dec_ctrl.alu_b_src = 1'b1;
                dec_ctrl.rd_wen    = 1'b1;
                imm32              = {{20{if_id__ins[31]}}, if_id__ins[31:20]};
            end
            7'b0000011: begin
                dec_ctrl.alu_b_src     = 1'b1;
                dec_ctrl.dmem_width    = funct3[1:0];
                dec_ctrl.dmem_zero_ext = funct3[2];
                dec_ctrl.dmem_read     = 1'b1;
                dec_ctrl.rd_wen        = 1'b1;
                dec_ctrl.rd_src        = RD_MEM;
                imm32                  = {{20{if_id__ins[31]}}, if_id__ins[31:20]};
            end
            7'b0100011: begin
                dec_ctrl.alu_b_src  = 1'b1;
                dec_ctrl.dmem_width = funct3[1:0];
                dec_ctrl.dmem_write = 1'b1;
                imm32 = {{20{if_id__ins[31]}}, if_id__ins[31:25], if_id__ins[11:7]};
            end
            7'b1100011: begin
                dec_ctrl.alu_op    = funct3[2] ? {2'b00, 1'b1, funct3[1]} : 4'b1000;
                dec_ctrl.jump_cond = (funct3[2] ^ funct3[0]) ? COND_NONZERO : COND_ZERO;
                imm32 = {{19{if_id__ins[31]}}, if_id__ins[31], if_id__ins[7],
                         if_id__ins[30:25], if_id__ins[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_ctrl.jump_cond = COND_ALWAYS;
                dec_ctrl.rd_wen    = 1'b1;
                dec_ctrl.rd_src    = RD_PC4;
                imm32 = {{11{if_id__ins[31]}}, if_id__ins[31], if_id__ins[19:12],
                         if_id__ins[20], if_id__ins[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_ctrl.jump_base_src = 1'b1;
                dec_ctrl.jump_cond     = COND_ALWAYS;
                dec_ctrl.rd_wen        = 1'b1;
                dec_ctrl.rd_src        = RD_PC4;
                imm32                  = {{20{if_id__ins[31]}}, if_id__ins[31:20]};
            end
            7'b0110111: begin
                dec_ctrl.alu_a_src = A_ZERO;
                dec_ctrl.alu_b_src = 1'b1;
                dec_ctrl.rd_wen    = 1'b1;
                imm32              = {if_id__ins[31:12], 12'b0};
            end
            7'b0010111: begin
                dec_ctrl.alu_a_src = A_PC;
                dec_ctrl.alu_b_src = 1'b1;
                dec_ctrl.rd_wen    = 1'b1;
                imm32              = {if_id__ins[31:12], 12'b0};
            end
            default: dec_ctrl = CTRL_BUBBLE;
        endcase
    end

    assign wb_live  = wb_id__rd_wen && (wb_id__rd_addr != '0);
    assign rs1_read = (rs1_dec == '0) ? '0 :
                      (wb_live && wb_id__rd_addr == rs1_dec) ? wb_id__rd_wdata : rf_q[rs1_dec];
    assign rs2_read = (rs2_dec == '0) ? '0 :
                      (wb_live && wb_id__rd_addr == rs2_dec) ? wb_id__rd_wdata : rf_q[rs2_dec];

    assign hz = valid_q && ctrl_q.dmem_read && (rd_addr_q != '0) &&
                ((rd_addr_q == rs1_dec) || (rd_addr_q == rs2_dec));
    assign if_id__stall = !pipe_flush && (!id_ex__ready || hz || state_q == STALL);

    // Flush beats everything; without ready nothing moves; otherwise stall/hazard insert bubbles
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        take_bubble  = 1'b0;
        take_capture = 1'b0;
        if (pipe_flush) begin
            take_bubble = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (id_ex__ready) begin
            if (state_q == STALL) begin
                take_bubble = 1'b1;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RUN;
            end else if (hz) begin
                take_bubble = 1'b1;
                if (LOAD_LATENCY > 1) begin
                    state_d = STALL;
                    cnt_d   = CNT_INIT;
                end
            end else if (if_id__valid) begin
                take_capture = 1'b1;
            end else begin
                take_bubble = 1'b1;
            end
        end
    end

    // Held operands follow writeback so a stalled instruction never sees stale data
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        rs1_data_d = (wb_live && wb_id__rd_addr == rs1_addr_q) ? wb_id__rd_wdata : rs1_data_q;
        rs2_data_d = (wb_live && wb_id__rd_addr == rs2_addr_q) ? wb_id__rd_wdata : rs2_data_q;
        if (take_bubble) begin
            valid_d    = 1'b0;
            pc_d       = BUBBLE_PC;
            imm_d      = '0;
            ctrl_d     = CTRL_BUBBLE;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
        end else if (take_capture) begin
            valid_d    = 1'b1;
            pc_d       = if_id__pc;
            imm_d      = XLEN'($signed(imm32));
            ctrl_d     = dec_ctrl;
            rs1_addr_d = rs1_dec;
            rs2_addr_d = rs2_dec;
            rd_addr_d  = rd_dec;
            rs1_data_d = rs1_read;
            rs2_data_d = rs2_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            pc_q       <= BUBBLE_PC;
            imm_q      <= '0;
            ctrl_q     <= CTRL_BUBBLE;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_live) rf_q[wb_id__rd_addr] <= wb_id__rd_wdata;
    end

    assign id_ex__valid     = valid_q;
    assign id_ex__pc        = pc_q;
    assign id_ex__imm       = imm_q;
    assign id_ex__rs1_rdata = rs1_data_q;
    assign id_ex__rs2_rdata = rs2_data_q;
    assign id_ex__rs1_addr  = rs1_addr_q;
    assign id_ex__rs2_addr  = rs2_addr_q;
    assign id_ex__rd_addr   = rd_addr_q;
    assign id_ex__ctrl      = ctrl_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe with LOAD_LATENCY=2: reset, bypass, load-use,
// back-pressure with operand coherence, flush and reset during a stall.
module tb_decode_pipe;

    logic        clk;
    logic        rst;
    logic        pipe_flush;
    logic        if_id__valid;
    logic [31:0] if_id__pc;
    logic [31:0] if_id__ins;
    logic        if_id__stall;
    logic        wb_id__rd_wen;
    logic [4:0]  wb_id__rd_addr;
    logic [31:0] wb_id__rd_wdata;
    logic        id_ex__ready;
    logic        id_ex__valid;
    logic [31:0] id_ex__pc;
    logic [31:0] id_ex__imm;
    logic [31:0] id_ex__rs1_rdata;
    logic [31:0] id_ex__rs2_rdata;
    logic [4:0]  id_ex__rs1_addr;
    logic [4:0]  id_ex__rs2_addr;
    logic [4:0]  id_ex__rd_addr;
    logic [17:0] id_ex__ctrl;

    int check_count = 0;
    int error_count = 0;

    localparam logic [31:0] BUBBLE = 32'hFFFF_FFFF;
    localparam logic [17:0] CTRL_ADD = 18'h00004;
    localparam logic [17:0] CTRL_LW  = 18'h00C85;

    decode_pipe #(.XLEN(32), .REG_COUNT(32), .LOAD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
        .if_id__valid(if_id__valid), .if_id__pc(if_id__pc), .if_id__ins(if_id__ins),
        .if_id__stall(if_id__stall),
        .wb_id__rd_wen(wb_id__rd_wen), .wb_id__rd_addr(wb_id__rd_addr),
        .wb_id__rd_wdata(wb_id__rd_wdata),
        .id_ex__ready(id_ex__ready), .id_ex__valid(id_ex__valid), .id_ex__pc(id_ex__pc),
        .id_ex__imm(id_ex__imm), .id_ex__rs1_rdata(id_ex__rs1_rdata),
        .id_ex__rs2_rdata(id_ex__rs2_rdata), .id_ex__rs1_addr(id_ex__rs1_addr),
        .id_ex__rs2_addr(id_ex__rs2_addr), .id_ex__rd_addr(id_ex__rd_addr),
        .id_ex__ctrl(id_ex__ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic ready, input logic flush, input logic wen,
                                 input logic [4:0] waddr, input logic [31:0] wdata);
        if_id__valid    = valid;
        if_id__pc       = pc;
        if_id__ins      = ins;
        id_ex__ready    = ready;
        pipe_flush      = flush;
        wb_id__rd_wen   = wen;
        wb_id__rd_addr  = waddr;
        wb_id__rd_wdata = wdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        tick();
        tick();
        checkOutput("reset_valid", {31'b0, id_ex__valid}, 32'h0);
        checkOutput("reset_pc", id_ex__pc, BUBBLE);
        checkOutput("reset_rd_wen", {31'b0, id_ex__ctrl[2]}, 32'h0);
        checkOutput("reset_jump_cond", {30'b0, id_ex__ctrl[4:3]}, 32'h0);
        checkOutput("reset_imm", id_ex__imm, 32'h0);
        checkOutput("reset_rs1_rdata", id_ex__rs1_rdata, 32'h0);
        rst = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("reset_stall", {31'b0, if_id__stall}, 32'h0);

        applyStimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd1, 32'h10);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd2, 32'h200);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd7, 32'h11);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd5, 32'h1234);
        tick();

        applyStimulus(1, 32'h10, enc_add(5'd1, 5'd5, 5'd0), 1, 0, 0, 5'd0, 32'h0);
        tick();
        checkOutput("rd_x5_rdata", id_ex__rs1_rdata, 32'h1234);
        checkOutput("rd_x0_rdata", id_ex__rs2_rdata, 32'h0);
        checkOutput("add_valid", {31'b0, id_ex__valid}, 32'h1);
        checkOutput("add_pc", id_ex__pc, 32'h10);
        checkOutput("add_ctrl", {14'b0, id_ex__ctrl}, {14'b0, CTRL_ADD});
        checkOutput("add_rd_addr", {27'b0, id_ex__rd_addr}, 32'd1);
        checkOutput("add_rs1_addr", {27'b0, id_ex__rs1_addr}, 32'd5);

        applyStimulus(1, 32'h14, enc_add(5'd1, 5'd3, 5'd3), 1, 0, 1, 5'd3, 32'hDEAD_BEEF);
        tick();
        checkOutput("bypass_rs1", id_ex__rs1_rdata, 32'hDEAD_BEEF);
        checkOutput("bypass_rs2", id_ex__rs2_rdata, 32'hDEAD_BEEF);

        applyStimulus(1, 32'h18, enc_add(5'd2, 5'd0, 5'd0), 1, 0, 1, 5'd0, 32'h0000_FFFF);
        tick();
        checkOutput("x0_write_rs1", id_ex__rs1_rdata, 32'h0);
        checkOutput("x0_write_rs2", id_ex__rs2_rdata, 32'h0);

        applyStimulus(1, 32'h100, enc_lw(5'd4, 5'd2, 12'h008), 1, 0, 0, 5'd0, 32'h0);
        checkOutput("lw_no_stall", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("lw_ctrl", {14'b0, id_ex__ctrl}, {14'b0, CTRL_LW});
        checkOutput("lw_imm", id_ex__imm, 32'h8);
        checkOutput("lw_rs1_rdata", id_ex__rs1_rdata, 32'h200);
        checkOutput("lw_rd_addr", {27'b0, id_ex__rd_addr}, 32'd4);
        applyStimulus(1, 32'h104, enc_add(5'd5, 5'd4, 5'd1), 1, 0, 0, 5'd0, 32'h0);
        checkOutput("lu_stall_c1", {31'b0, if_id__stall}, 32'h1);
        tick();
        checkOutput("lu_bubble1_valid", {31'b0, id_ex__valid}, 32'h0);
        checkOutput("lu_bubble1_pc", id_ex__pc, BUBBLE);
        checkOutput("lu_stall_c2", {31'b0, if_id__stall}, 32'h1);
        tick();
        checkOutput("lu_bubble2_valid", {31'b0, id_ex__valid}, 32'h0);
        checkOutput("lu_bubble2_pc", id_ex__pc, BUBBLE);
        checkOutput("lu_stall_c3", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("lu_issue_valid", {31'b0, id_ex__valid}, 32'h1);
        checkOutput("lu_issue_pc", id_ex__pc, 32'h104);
        checkOutput("lu_issue_rs1_addr", {27'b0, id_ex__rs1_addr}, 32'd4);

        applyStimulus(1, 32'h200, enc_lw(5'd0, 5'd1, 12'h000), 1, 0, 0, 5'd0, 32'h0);
        tick();
        applyStimulus(1, 32'h204, enc_add(5'd5, 5'd0, 5'd1), 1, 0, 0, 5'd0, 32'h0);
        checkOutput("lw_x0_no_stall", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("lw_x0_next_pc", id_ex__pc, 32'h204);
        checkOutput("lw_x0_next_valid", {31'b0, id_ex__valid}, 32'h1);

        applyStimulus(1, 32'h300, enc_add(5'd6, 5'd1, 5'd7), 1, 0, 0, 5'd0, 32'h0);
        tick();
        checkOutput("bp_pre_rs2", id_ex__rs2_rdata, 32'h11);
        applyStimulus(1, 32'h304, enc_add(5'd8, 5'd1, 5'd1), 0, 0, 1, 5'd7, 32'h55);
        checkOutput("bp_stall", {31'b0, if_id__stall}, 32'h1);
        tick();
        checkOutput("bp_hold_pc1", id_ex__pc, 32'h300);
        checkOutput("bp_coherent_rs2", id_ex__rs2_rdata, 32'h55);
        checkOutput("bp_hold_rs1", id_ex__rs1_rdata, 32'h10);
        applyStimulus(1, 32'h304, enc_add(5'd8, 5'd1, 5'd1), 0, 0, 0, 5'd0, 32'h0);
        tick();
        tick();
        checkOutput("bp_hold_pc3", id_ex__pc, 32'h300);
        checkOutput("bp_hold_valid", {31'b0, id_ex__valid}, 32'h1);
        checkOutput("bp_hold_rd", {27'b0, id_ex__rd_addr}, 32'd6);
        checkOutput("bp_hold_rs2", id_ex__rs2_rdata, 32'h55);
        applyStimulus(1, 32'h304, enc_add(5'd8, 5'd1, 5'd1), 1, 0, 0, 5'd0, 32'h0);
        checkOutput("bp_release_stall", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("bp_advance_pc", id_ex__pc, 32'h304);
        checkOutput("bp_advance_rd", {27'b0, id_ex__rd_addr}, 32'd8);

        applyStimulus(1, 32'h400, enc_lw(5'd4, 5'd2, 12'hFFC), 1, 0, 0, 5'd0, 32'h0);
        tick();
        checkOutput("lw_neg_imm", id_ex__imm, 32'hFFFF_FFFC);
        applyStimulus(1, 32'h404, enc_add(5'd5, 5'd4, 5'd4), 1, 0, 0, 5'd0, 32'h0);
        tick();
        checkOutput("fl_in_stall", {31'b0, if_id__stall}, 32'h1);
        applyStimulus(1, 32'h404, enc_add(5'd5, 5'd4, 5'd4), 1, 1, 0, 5'd0, 32'h0);
        checkOutput("fl_stall_drop", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("fl_bubble_valid", {31'b0, id_ex__valid}, 32'h0);
        checkOutput("fl_bubble_pc", id_ex__pc, BUBBLE);
        applyStimulus(1, 32'h408, enc_add(5'd9, 5'd1, 5'd1), 1, 0, 0, 5'd0, 32'h0);
        checkOutput("fl_run_stall", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("fl_next_valid", {31'b0, id_ex__valid}, 32'h1);
        checkOutput("fl_next_pc", id_ex__pc, 32'h408);

        applyStimulus(1, 32'h500, enc_lw(5'd4, 5'd2, 12'h000), 1, 0, 0, 5'd0, 32'h0);
        tick();
        applyStimulus(1, 32'h504, enc_add(5'd5, 5'd4, 5'd1), 1, 0, 0, 5'd0, 32'h0);
        tick();
        checkOutput("rs_in_stall", {31'b0, if_id__stall}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rs_valid", {31'b0, id_ex__valid}, 32'h0);
        checkOutput("rs_stall", {31'b0, if_id__stall}, 32'h0);
        tick();
        checkOutput("rs_next_valid", {31'b0, id_ex__valid}, 32'h1);
        checkOutput("rs_next_pc", id_ex__pc, 32'h504);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
